// File: rtl/rotary_accel.sv
// -----------------------------------------------------------------------------
// rotary_accel
//
// Turns the single-cycle detent strobes from a rotary decoder into a bounded,
// saturating setting value. The step applied per detent grows with turn speed:
// consecutive detents in the same direction that arrive quickly use FAST_STEP,
// moderately spaced ones use MED_STEP, and anything else (idle, reversal,
// first detent after reset or load) moves by 1.
//
// Handshake: there is no back-pressure. rot_cw, rot_ccw and load are
// single-cycle strobes sampled on every posedge clk. A detent is accepted when
// exactly one of rot_cw/rot_ccw is high and load is low. load wins over any
// detent strobe in the same cycle. All results are registered and visible the
// cycle after the sampling edge.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-low reset
//   rot_cw     one-cycle clockwise detent strobe
//   rot_ccw    one-cycle counter-clockwise detent strobe
//   load       one-cycle request to overwrite value
//   load_val   value to load, clamped to [MIN_VAL, MAX_VAL]
//   value      current setting (registered)
//   step       step magnitude of the last accepted detent (registered)
//   changed    one-cycle pulse when value actually changed
//   at_min     value == MIN_VAL
//   at_max     value == MAX_VAL
//   dbg_state  FSM state (0 IDLE, 1 CW_RUN, 2 CCW_RUN) for observation
// -----------------------------------------------------------------------------
module rotary_accel #(
    parameter int WIDTH      = 16,
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 1000,
    parameter int RESET_VAL  = 0,
    parameter int FAST_TICKS = 500000,
    parameter int MED_TICKS  = 2500000,
    parameter int FAST_STEP  = 10,
    parameter int MED_STEP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rot_cw,
    input  logic             rot_ccw,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] step,
    output logic             changed,
    output logic             at_min,
    output logic             at_max,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CW_RUN  = 2'd1,
        CCW_RUN = 2'd2
    } state_e;

    // Timer only needs to reach MED_TICKS, where it saturates.
    localparam int TW = $clog2(MED_TICKS + 1);

    localparam logic [TW-1:0]    TMR_MAX  = TW'(MED_TICKS);
    localparam logic [TW-1:0]    TMR_FAST = TW'(FAST_TICKS);
    localparam logic [TW-1:0]    TMR_ONE  = TW'(1);

    localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] FAST_V   = WIDTH'(FAST_STEP);
    localparam logic [WIDTH-1:0] MED_V    = WIDTH'(MED_STEP);
    localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);

    localparam logic [WIDTH:0]   MIN_W    = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_W    = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0]   ONE_W    = (WIDTH + 1)'(1);

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             changed_q, changed_d;

    logic             cw_evt, ccw_evt, same_dir;
    logic [WIDTH-1:0] sel_step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   floor_w;

    // Both strobes high together is treated as no event at all.
    assign cw_evt  = rot_cw & ~rot_ccw & ~load;
    assign ccw_evt = rot_ccw & ~rot_cw & ~load;

    assign same_dir = (cw_evt && state_q == CW_RUN) || (ccw_evt && state_q == CCW_RUN);

    // timer_q holds the number of cycles since the previous accepted detent.
    always_comb begin
        sel_step = ONE_V;
        if (same_dir && timer_q < TMR_FAST) begin
            sel_step = FAST_V;
        end else if (same_dir && timer_q < TMR_MAX) begin
            sel_step = MED_V;
        end
    end

    // Extra bit keeps the sum and the lower-bound test free of wrap-around.
    assign sum_w   = {1'b0, value_q} + {1'b0, sel_step};
    assign floor_w = MIN_W + {1'b0, sel_step};

    // "load_val + 1 <= MIN" is load_val < MIN without a degenerate compare
    // against zero when MIN_VAL is 0.
    always_comb begin
        load_clamped = load_val;
        if ({1'b0, load_val} + ONE_W <= MIN_W) begin
            load_clamped = MIN_V;
        end else if ({1'b0, load_val} > MAX_W) begin
            load_clamped = MAX_V;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        value_d = value_q;
        step_d  = step_q;

        if (load) begin
            value_d = load_clamped;
            state_d = IDLE;
            timer_d = TMR_MAX;
        end else if (cw_evt) begin
            step_d  = sel_step;
            timer_d = TMR_ONE;
            state_d = CW_RUN;
            value_d = (sum_w > MAX_W) ? MAX_V : sum_w[WIDTH-1:0];
        end else if (ccw_evt) begin
            step_d  = sel_step;
            timer_d = TMR_ONE;
            state_d = CCW_RUN;
            value_d = ({1'b0, value_q} >= floor_w) ? (value_q - sel_step) : MIN_V;
        end else begin
            if (timer_q < TMR_MAX) begin
                timer_d = timer_q + TMR_ONE;
            end
            // A run ends once the interval grows past the medium window.
            if (timer_d == TMR_MAX) begin
                state_d = IDLE;
            end
        end

        changed_d = (value_d != value_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= TMR_MAX;
            value_q   <= RST_V;
            step_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            value_q   <= value_d;
            step_q    <= step_d;
            changed_q <= changed_d;
        end
    end

    assign value     = value_q;
    assign step      = step_q;
    assign changed   = changed_q;
    assign at_min    = (value_q == MIN_V);
    assign at_max    = (value_q == MAX_V);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rotary_accel.sv
module tb_rotary_accel;

    logic       clk;
    logic       rst;
    logic       rot_cw;
    logic       rot_ccw;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] value;
    logic [7:0] step;
    logic       changed;
    logic       at_min;
    logic       at_max;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CW   = 2'd1;
    localparam logic [1:0] S_CCW  = 2'd2;

    rotary_accel #(
        .WIDTH     (8),
        .MIN_VAL   (0),
        .MAX_VAL   (100),
        .RESET_VAL (50),
        .FAST_TICKS(4),
        .MED_TICKS (10),
        .FAST_STEP (8),
        .MED_STEP  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rot_cw   (rot_cw),
        .rot_ccw  (rot_ccw),
        .load     (load),
        .load_val (load_val),
        .value    (value),
        .step     (step),
        .changed  (changed),
        .at_min   (at_min),
        .at_max   (at_max),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    // All driving happens on negedge; a strobe is held for exactly one cycle
    // and outputs are sampled at the following negedge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pulse(input logic cw, input logic ccw, input logic ld,
                               input logic [7:0] lv);
        rot_cw   = cw;
        rot_ccw  = ccw;
        load     = ld;
        load_val = lv;
        @(negedge clk);
        rot_cw   = 1'b0;
        rot_ccw  = 1'b0;
        load     = 1'b0;
        load_val = 8'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        checks++; if (value !== 8'd50) begin failures++; $display("FAIL reset_value got=%0d exp=50", value); end
        checks++; if (step !== 8'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", step); end
        checks++; if (changed !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", changed); end
        checks++; if (at_min !== 1'b0 || at_max !== 1'b0) begin failures++; $display("FAIL reset_limits got=%b%b exp=00", at_min, at_max); end
        checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    // cw pulses at t0, t0+3, t0+9, t0+25: intervals 3, 6, 16.
    task automatic test_cw_accel();
        int         gap[4]  = '{0, 2, 5, 15};
        logic [7:0] ev[4]   = '{8'd51, 8'd59, 8'd62, 8'd63};
        logic [7:0] es[4]   = '{8'd1, 8'd8, 8'd3, 8'd1};
        for (int i = 0; i < 4; i++) begin
            if (gap[i] > 0) begin
                idle(1);
                checks++; if (changed !== 1'b0) begin failures++; $display("FAIL cw_accel_pulse_drop[%0d] got=%b exp=0", i, changed); end
                idle(gap[i] - 1);
            end
            if (i == 3) begin
                checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL cw_accel_timeout_idle got=%0d exp=0", dbg_state); end
            end
            drive_pulse(1'b1, 1'b0, 1'b0, 8'd0);
            checks++; if (value !== ev[i]) begin failures++; $display("FAIL cw_accel_value[%0d] got=%0d exp=%0d", i, value, ev[i]); end
            checks++; if (step !== es[i]) begin failures++; $display("FAIL cw_accel_step[%0d] got=%0d exp=%0d", i, step, es[i]); end
            checks++; if (changed !== 1'b1) begin failures++; $display("FAIL cw_accel_changed[%0d] got=%b exp=1", i, changed); end
        end
        checks++; if (dbg_state !== S_CW) begin failures++; $display("FAIL cw_accel_state got=%0d exp=1", dbg_state); end
    endtask

    // load 50, cw at t0, ccw at t0+2, ccw at t0+4.
    task automatic test_reversal();
        logic       cw[3]  = '{1'b1, 1'b0, 1'b0};
        logic [7:0] ev[3]  = '{8'd51, 8'd50, 8'd42};
        logic [7:0] es[3]  = '{8'd1, 8'd1, 8'd8};
        drive_pulse(1'b0, 1'b0, 1'b1, 8'd50);
        checks++; if (value !== 8'd50 || changed !== 1'b1) begin failures++; $display("FAIL rev_load got=%0d/%b exp=50/1", value, changed); end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            drive_pulse(cw[i], ~cw[i], 1'b0, 8'd0);
            checks++; if (value !== ev[i]) begin failures++; $display("FAIL rev_value[%0d] got=%0d exp=%0d", i, value, ev[i]); end
            checks++; if (step !== es[i]) begin failures++; $display("FAIL rev_step[%0d] got=%0d exp=%0d", i, step, es[i]); end
        end
        checks++; if (dbg_state !== S_CCW) begin failures++; $display("FAIL rev_state got=%0d exp=2", dbg_state); end
    endtask

    // load 97 then cw at intervals 1, 2, 2: clamp at 100.
    task automatic test_max_clamp();
        int         gap[3] = '{0, 1, 1};
        logic [7:0] es[3]  = '{8'd1, 8'd8, 8'd8};
        logic [7:0] ev[3]  = '{8'd98, 8'd100, 8'd100};
        logic       ec[3]  = '{1'b1, 1'b1, 1'b0};
        logic       em[3]  = '{1'b0, 1'b1, 1'b1};
        drive_pulse(1'b0, 1'b0, 1'b1, 8'd97);
        checks++; if (value !== 8'd97 || dbg_state !== S_IDLE) begin failures++; $display("FAIL max_load got=%0d/%0d exp=97/0", value, dbg_state); end
        for (int i = 0; i < 3; i++) begin
            idle(gap[i]);
            drive_pulse(1'b1, 1'b0, 1'b0, 8'd0);
            checks++; if (value !== ev[i]) begin failures++; $display("FAIL max_value[%0d] got=%0d exp=%0d", i, value, ev[i]); end
            checks++; if (step !== es[i]) begin failures++; $display("FAIL max_step[%0d] got=%0d exp=%0d", i, step, es[i]); end
            checks++; if (changed !== ec[i]) begin failures++; $display("FAIL max_changed[%0d] got=%b exp=%b", i, changed, ec[i]); end
            checks++; if (at_max !== em[i]) begin failures++; $display("FAIL max_at_max[%0d] got=%b exp=%b", i, at_max, em[i]); end
        end
    endtask

    // load vs cw priority, load clamp, both-strobes ignored while timer runs.
    task automatic test_load_priority();
        drive_pulse(1'b1, 1'b0, 1'b1, 8'd200);
        checks++; if (value !== 8'd100 || changed !== 1'b0) begin failures++; $display("FAIL prio_value got=%0d/%b exp=100/0", value, changed); end
        checks++; if (step !== 8'd8 || dbg_state !== S_IDLE) begin failures++; $display("FAIL prio_step_state got=%0d/%0d exp=8/0", step, dbg_state); end
        drive_pulse(1'b0, 1'b0, 1'b1, 8'd20);
        checks++; if (value !== 8'd20 || changed !== 1'b1 || at_max !== 1'b0) begin failures++; $display("FAIL prio_load20 got=%0d/%b/%b exp=20/1/0", value, changed, at_max); end
        idle(1);
        drive_pulse(1'b1, 1'b0, 1'b0, 8'd0);
        checks++; if (value !== 8'd21 || step !== 8'd1) begin failures++; $display("FAIL prio_after_load got=%0d/%0d exp=21/1", value, step); end
        idle(2);
        drive_pulse(1'b1, 1'b1, 1'b0, 8'd0);
        checks++; if (value !== 8'd21 || step !== 8'd1 || changed !== 1'b0 || dbg_state !== S_CW) begin
            failures++; $display("FAIL both_ignored got=%0d/%0d/%b/%0d exp=21/1/0/1", value, step, changed, dbg_state);
        end
        // Interval since the last cw is 5, so the both-high cycle must not
        // have restarted the timer (that would give interval 2 and step 8).
        idle(1);
        drive_pulse(1'b1, 1'b0, 1'b0, 8'd0);
        checks++; if (value !== 8'd24 || step !== 8'd3) begin failures++; $display("FAIL both_timer_runs got=%0d/%0d exp=24/3", value, step); end
    endtask

    // Back-to-back fast run, then reset mid-rotation.
    task automatic test_back_to_back_reset();
        logic [7:0] ev[3] = '{8'd32, 8'd40, 8'd48};
        for (int i = 0; i < 3; i++) begin
            drive_pulse(1'b1, 1'b0, 1'b0, 8'd0);
            checks++; if (value !== ev[i] || step !== 8'd8 || changed !== 1'b1) begin
                failures++; $display("FAIL b2b[%0d] got=%0d/%0d/%b exp=%0d/8/1", i, value, step, changed, ev[i]);
            end
        end
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        checks++; if (value !== 8'd50 || step !== 8'd0 || changed !== 1'b0 || dbg_state !== S_IDLE) begin
            failures++; $display("FAIL midrun_reset got=%0d/%0d/%b/%0d exp=50/0/0/0", value, step, changed, dbg_state);
        end
        drive_pulse(1'b1, 1'b0, 1'b0, 8'd0);
        checks++; if (value !== 8'd51 || step !== 8'd1 || changed !== 1'b1) begin
            failures++; $display("FAIL after_reset got=%0d/%0d/%b exp=51/1/1", value, step, changed);
        end
    endtask

    // ccw saturation at MIN_VAL.
    task automatic test_min_clamp();
        logic [7:0] ev[3] = '{8'd1, 8'd0, 8'd0};
        logic [7:0] es[3] = '{8'd1, 8'd8, 8'd8};
        logic       ec[3] = '{1'b1, 1'b1, 1'b0};
        logic       em[3] = '{1'b0, 1'b1, 1'b1};
        drive_pulse(1'b0, 1'b0, 1'b1, 8'd2);
        checks++; if (value !== 8'd2) begin failures++; $display("FAIL min_load got=%0d exp=2", value); end
        for (int i = 0; i < 3; i++) begin
            drive_pulse(1'b0, 1'b1, 1'b0, 8'd0);
            checks++; if (value !== ev[i] || step !== es[i]) begin failures++; $display("FAIL min_value_step[%0d] got=%0d/%0d exp=%0d/%0d", i, value, step, ev[i], es[i]); end
            checks++; if (changed !== ec[i] || at_min !== em[i]) begin failures++; $display("FAIL min_flags[%0d] got=%b/%b exp=%b/%b", i, changed, at_min, ec[i], em[i]); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst      = 1'b0;
        rot_cw   = 1'b0;
        rot_ccw  = 1'b0;
        load     = 1'b0;
        load_val = 8'd0;
        @(negedge clk);
        test_reset();
        test_cw_accel();
        test_reversal();
        test_max_clamp();
        test_load_priority();
        test_back_to_back_reset();
        test_min_clamp();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
